// File: rtl/pin_debounce_pkg.sv
// rtl/pin_debounce_pkg.sv - shared constants and width helpers for pin_debounce
package pin_debounce_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 2;
  localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_RESET_VAL = '1;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Counter must hold 0..DEPTH-1; sized from DEPTH+1 so DEPTH=1 still gets one bit.
  function automatic int cnt_w(input int depth);
    return clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pin_debounce_ch.sv
// rtl/pin_debounce_ch.sv - one debounce channel: disagreement counter, filtered output, edge pulses
module pin_debounce_ch
  import pin_debounce_pkg::*;
#(
  parameter int   DEPTH     = DEFAULT_DEPTH,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ena_i,
  input  logic bypass_i,
  input  logic sample_i,
  output logic dout_o,
  output logic rise_o,
  output logic fall_o,
  output logic flip_o
);

  localparam int CNT_W = cnt_w(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_comb begin
    cnt_d  = cnt_q;
    dout_d = dout_q;
    if (ena_i) begin
      if (bypass_i) begin
        dout_d = sample_i;
        cnt_d  = '0;
      end else if (sample_i == dout_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        dout_d = sample_i;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    rise_d = dout_d & ~dout_q;
    fall_d = ~dout_d & dout_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      dout_q <= RESET_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign dout_o = dout_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;
  // Next-cycle pulse, so the top can register changed in step with rise/fall.
  assign flip_o = rise_d | fall_d;

endmodule

// File: rtl/pin_debounce.sv
// rtl/pin_debounce.sv - multi-channel GPIO debouncer; PIN_DEBOUNCE_SYNC_EN adds a 2-flop input synchronizer
module pin_debounce
  import pin_debounce_pkg::*;
#(
  parameter int               WIDTH     = DEFAULT_WIDTH,
  parameter int               DEPTH     = DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] din,
  input  logic             ena,
  input  logic [WIDTH-1:0] bypass,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  logic [WIDTH-1:0] sample;
  logic [WIDTH-1:0] flip;
  logic             changed_q, changed_d;

`ifdef PIN_DEBOUNCE_SYNC_EN
  logic [WIDTH-1:0] sync1_q, sync2_q;

  // Free-running on clk so metastability settles regardless of the strobe rate.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= RESET_VAL;
      sync2_q <= RESET_VAL;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
    end
  end

  assign sample = sync2_q;
`else
  assign sample = din;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    pin_debounce_ch #(
      .DEPTH    (DEPTH),
      .RESET_VAL(RESET_VAL[i])
    ) u_ch (
      .clk     (clk),
      .reset_n (reset_n),
      .ena_i   (ena),
      .bypass_i(bypass[i]),
      .sample_i(sample[i]),
      .dout_o  (dout[i]),
      .rise_o  (rise[i]),
      .fall_o  (fall[i]),
      .flip_o  (flip[i])
    );
  end

  assign changed_d = |flip;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= changed_d;
    end
  end

  assign changed = changed_q;

endmodule

// File: tb/tb_pin_debounce.sv
// tb/tb_pin_debounce.sv - randomized model-checked bench for pin_debounce at DEPTH 3, 2 and 1
module tb_pin_debounce;

`ifdef PIN_DEBOUNCE_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif
  localparam int NI = 3;
  localparam int DEP [NI] = '{3, 2, 1};

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] din;
  logic       ena;
  logic [7:0] bypass;

  logic [7:0] dout_w [NI];
  logic [7:0] rise_w [NI];
  logic [7:0] fall_w [NI];
  logic       chg_w  [NI];

  int vectors = 0;
  int misc    = 0;

  always #5 clk = ~clk;

  pin_debounce #(.WIDTH(8), .DEPTH(3)) u_d3 (
    .clk(clk), .reset_n(reset_n), .din(din), .ena(ena), .bypass(bypass),
    .dout(dout_w[0]), .rise(rise_w[0]), .fall(fall_w[0]), .changed(chg_w[0]));
  pin_debounce #(.WIDTH(8), .DEPTH(2)) u_d2 (
    .clk(clk), .reset_n(reset_n), .din(din), .ena(ena), .bypass(bypass),
    .dout(dout_w[1]), .rise(rise_w[1]), .fall(fall_w[1]), .changed(chg_w[1]));
  pin_debounce #(.WIDTH(8), .DEPTH(1)) u_d1 (
    .clk(clk), .reset_n(reset_n), .din(din), .ena(ena), .bypass(bypass),
    .dout(dout_w[2]), .rise(rise_w[2]), .fall(fall_w[2]), .changed(chg_w[2]));

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      misc++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: each pin's output flips once it has seen DEPTH strobe samples in a row that differ from it.
  logic [7:0] m_dout [NI];
  logic [7:0] m_rise [NI];
  logic [7:0] m_fall [NI];
  logic       m_chg  [NI];
  int         m_run  [NI][8];
  logic [7:0] m_s1, m_s2, m_samp, m_old;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int n = 0; n < NI; n++) begin
        m_dout[n] = 8'hFF; m_rise[n] = 8'h00; m_fall[n] = 8'h00; m_chg[n] = 1'b0;
        for (int c = 0; c < 8; c++) m_run[n][c] = 0;
      end
      m_s1 = 8'hFF; m_s2 = 8'hFF;
    end else begin
`ifdef PIN_DEBOUNCE_SYNC_EN
      m_samp = m_s2;
`else
      m_samp = din;
`endif
      m_s2 = m_s1;
      m_s1 = din;
      for (int n = 0; n < NI; n++) begin
        m_old = m_dout[n];
        if (ena) begin
          for (int c = 0; c < 8; c++) begin
            if (bypass[c]) begin
              m_dout[n][c] = m_samp[c];
              m_run[n][c]  = 0;
            end else if (m_samp[c] == m_old[c]) begin
              m_run[n][c] = 0;
            end else begin
              m_run[n][c] = m_run[n][c] + 1;
              if (m_run[n][c] >= DEP[n]) begin
                m_dout[n][c] = m_samp[c];
                m_run[n][c]  = 0;
              end
            end
          end
        end
        m_rise[n] = m_dout[n] & ~m_old;
        m_fall[n] = m_old & ~m_dout[n];
        m_chg[n]  = |(m_rise[n] | m_fall[n]);
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      for (int n = 0; n < NI; n++) begin
        check($sformatf("dout[d%0d]", DEP[n]), dout_w[n], m_dout[n]);
        check($sformatf("rise[d%0d]", DEP[n]), rise_w[n], m_rise[n]);
        check($sformatf("fall[d%0d]", DEP[n]), fall_w[n], m_fall[n]);
        check($sformatf("changed[d%0d]", DEP[n]), 8'(chg_w[n]), 8'(m_chg[n]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    for (int n = 0; n < NI; n++) begin
      check({tag, "_dout"}, dout_w[n], 8'hFF);
      check({tag, "_rise"}, rise_w[n], 8'h00);
      check({tag, "_fall"}, fall_w[n], 8'h00);
      check({tag, "_chg"}, 8'(chg_w[n]), 8'h00);
    end
  endtask

  int   at3, at2, at1, cnt3;
  logic pat  [6];
  logic hist [8];

  initial begin
    reset_n = 1'b0; din = 8'hFF; ena = 1'b0; bypass = 8'h00;
    step();
    check_reset_state("reset_init");
    reset_n = 1'b1; ena = 1'b1;
    repeat (4) step();

    // DEPTH=3 fall on the 3rd sample; DEPTH=2 on the 2nd; changed coincides
    din = 8'hFE; at3 = -1; at2 = -1; cnt3 = 0;
    for (int k = 1; k <= 4 + SL; k++) begin
      step();
      if (fall_w[0][0]) begin
        at3 = k; cnt3++;
        check("d3_changed_with_fall", 8'(chg_w[0]), 8'h01);
        check("d3_other_channels", dout_w[0], 8'hFE);
      end
      if (fall_w[1][0]) at2 = k;
    end
    check("d3_fall_at", 8'(at3), 8'(3 + SL));
    check("d3_fall_count", 8'(cnt3), 8'h01);
    check("d2_fall_at", 8'(at2), 8'(2 + SL));
    check("d3_changed_cleared", 8'(chg_w[0]), 8'h00);

    // glitch: 1,1,0,1,1,1 -> DEPTH=3 flips only on the 6th sample
    pat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    at3 = -1; cnt3 = 0;
    for (int k = 0; k < 6 + SL; k++) begin
      if (k < 6) din[0] = pat[k];
      step();
      if (rise_w[0][0]) begin at3 = k + 1; cnt3++; end
    end
    check("glitch_at", 8'(at3), 8'(6 + SL));
    check("glitch_pulses", 8'(cnt3), 8'h01);

    // DEPTH=1 latency on din[3]
    at1 = -1;
    din[3] = 1'b0;
    for (int k = 1; k <= 3 + SL; k++) begin
      step();
      if (fall_w[2][3]) at1 = k;
    end
    check("d1_latency", 8'(at1), 8'(1 + SL));
    din[3] = 1'b1;
    repeat (4 + SL) step();

    // strobe every 4th clk: DEPTH=2 flips on strobe 2 (clk 4), DEPTH=3 on strobe 3 (clk 8)
    din[2] = 1'b0; ena = 1'b0;
    repeat (SL + 1) step();
    at2 = -1; at3 = -1;
    for (int i = 0; i <= 9; i++) begin
      ena = (i % 4 == 0);
      step();
      if (fall_w[1][2]) at2 = i;
      if (fall_w[0][2]) at3 = i;
      if (i >= 1 && i <= 3) check("gap_hold", 8'(dout_w[1][2]), 8'h01);
    end
    check("gap_d2_at", 8'(at2), 8'h04);
    check("gap_d3_at", 8'(at3), 8'h08);
    ena = 1'b1; din[2] = 1'b1;
    repeat (4 + SL) step();

    // bypass on ch1: dout follows each strobe, rise/fall alternate
    bypass[1] = 1'b1;
    for (int k = 0; k < 8; k++) begin
      hist[k] = (k % 2 == 1);
      din[1] = hist[k];
      step();
      if (k >= SL) begin
        check("byp_dout", 8'(dout_w[1][1]), 8'(hist[k-SL]));
        check("byp_rise", 8'(rise_w[1][1]), 8'(hist[k-SL]));
        check("byp_fall", 8'(fall_w[1][1]), 8'(!hist[k-SL]));
      end
    end
    repeat (SL) step();
    bypass[1] = 1'b0; din[1] = 1'b0;
    repeat (SL + 1) step();
    check("unbyp_first", 8'(dout_w[1][1]), 8'h01);
    step();
    check("unbyp_second", 8'(dout_w[1][1]), 8'h00);
    repeat (3) step();

    // random phase
    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < 8; c++)
        if ($urandom_range(0, 4) == 0) din[c] = ~din[c];
      ena = ($urandom_range(0, 3) != 0);
      if (k % 250 == 0) bypass = 8'($urandom) & 8'($urandom);
      if (k % 997 == 500) begin
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
      end
      step();
    end

    // asynchronous reset mid-run, sampled between edges
    bypass = 8'h00; ena = 1'b1; din = 8'h00;
    step();
    step();
    reset_n = 1'b0;
    #2;
    check_reset_state("reset_mid");
    step();
    step();
    reset_n = 1'b1;
    repeat (5) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

endmodule
